// File: rtl/instruction_controller_pkg.sv
// Shared defines for the controller and datapath: widths, FSM state encodings,
// opcode/op constants and the instruction classifier.
package instruction_controller_pkg;

   localparam int IC_WIDTH   = 16;
   localparam int IC_REGADDR = 3;

   typedef enum logic [2:0] {
      ST_WAIT      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_WRITE_IMM = 3'd2,
      ST_GET_A     = 3'd3,
      ST_GET_B     = 3'd4,
      ST_COMPUTE   = 3'd5,
      ST_WRITE_REG = 3'd6
   } state_e;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   typedef enum logic [2:0] {
      CLS_ILL  = 3'd0,
      CLS_MOVI = 3'd1,
      CLS_MOVR = 3'd2,
      CLS_ADD  = 3'd3,
      CLS_CMP  = 3'd4,
      CLS_AND  = 3'd5,
      CLS_MVN  = 3'd6
   } cls_e;

   function automatic cls_e classify(input logic [2:0] opcode, input logic [1:0] op);
      cls_e c;
      c = CLS_ILL;
      if (opcode == OPC_MOV) begin
         if (op == OP_MOV_IMM)      c = CLS_MOVI;
         else if (op == OP_MOV_REG) c = CLS_MOVR;
      end else if (opcode == OPC_ALU) begin
         case (op)
            OP_ADD:  c = CLS_ADD;
            OP_CMP:  c = CLS_CMP;
            OP_AND:  c = CLS_AND;
            default: c = CLS_MVN;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/instruction_controller_instr_decode.sv
// Combinational instruction decoder: splits the held IR into its fields,
// sign-extends imm8 to the datapath width and classifies the opcode/op pair.
module instr_decode
   import instruction_controller_pkg::*;
#(
   parameter int WIDTH   = IC_WIDTH,
   parameter int REGADDR = IC_REGADDR
) (
   input  logic [WIDTH-1:0]   ir_i,
   output logic [1:0]         op_o,
   output logic [REGADDR-1:0] rn_o,
   output logic [REGADDR-1:0] rd_o,
   output logic [1:0]         sh_o,
   output logic [REGADDR-1:0] rm_o,
   output logic [WIDTH-1:0]   sext_imm_o,
   output logic [2:0]         cls_o
);

   logic [2:0] opcode;

   assign opcode     = ir_i[15:13];
   assign op_o       = ir_i[12:11];
   assign rn_o       = ir_i[10:8];
   assign rd_o       = ir_i[7:5];
   assign sh_o       = ir_i[4:3];
   assign rm_o       = ir_i[2:0];
   assign sext_imm_o = {{(WIDTH-8){ir_i[7]}}, ir_i[7:0]};
   assign cls_o      = classify(opcode, op_o);

endmodule

// File: rtl/instruction_controller.sv
// Multi-cycle instruction controller: holds the instruction register and
// sequences register-file reads, the compute stage and writeback as a Moore FSM.
module instruction_controller
   import instruction_controller_pkg::*;
#(
   parameter int WIDTH   = IC_WIDTH,
   parameter int REGADDR = IC_REGADDR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               s,
   input  logic [WIDTH-1:0]   instr_in,
   output logic               w,
   output logic [REGADDR-1:0] readnum,
   output logic [REGADDR-1:0] writenum,
   output logic               write,
   output logic               loada,
   output logic               loadb,
   output logic               asel,
   output logic               bsel,
   output logic               loadc,
   output logic               loads,
   output logic [1:0]         shift,
   output logic [1:0]         ALUop,
   output logic               vsel,
   output logic [WIDTH-1:0]   datapath_in
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   ir_q, ir_d;

   logic [1:0]         op;
   logic [REGADDR-1:0] rn, rd, rm;
   logic [1:0]         sh;
   logic [2:0]         cls;

   instr_decode #(
      .WIDTH   (WIDTH),
      .REGADDR (REGADDR)
   ) u_decode (
      .ir_i       (ir_q),
      .op_o       (op),
      .rn_o       (rn),
      .rd_o       (rd),
      .sh_o       (sh),
      .rm_o       (rm),
      .sext_imm_o (datapath_in),
      .cls_o      (cls)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // IR only loads on an accepted start; s is ignored outside WAIT.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         ST_WAIT: begin
            if (s) begin
               ir_d    = instr_in;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (cls == CLS_MOVI)      state_d = ST_WRITE_IMM;
            else if (cls == CLS_MOVR) state_d = ST_GET_B;
            else if (cls == CLS_ILL)  state_d = ST_WAIT;
            else                      state_d = ST_GET_A;
         end
         ST_WRITE_IMM: state_d = ST_WAIT;
         ST_GET_A:     state_d = ST_GET_B;
         ST_GET_B:     state_d = ST_COMPUTE;
         ST_COMPUTE:   state_d = (cls == CLS_CMP) ? ST_WAIT : ST_WRITE_REG;
         ST_WRITE_REG: state_d = ST_WAIT;
         default:      state_d = ST_WAIT;
      endcase
   end

   always_comb begin
      w        = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      shift    = 2'b00;
      ALUop    = 2'b00;
      vsel     = 1'b0;
      case (state_q)
         ST_WAIT: w = 1'b1;
         ST_WRITE_IMM: begin
            writenum = rn;
            write    = 1'b1;
            vsel     = 1'b1;
         end
         ST_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
         end
         ST_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
         end
         // MOV-reg passes the shifted B operand straight through with A gated off.
         ST_COMPUTE: begin
            shift = sh;
            asel  = (cls != CLS_MOVR);
            ALUop = (cls == CLS_MOVR) ? 2'b00 : op;
            if (cls == CLS_CMP) loads = 1'b1;
            else                loadc = 1'b1;
         end
         ST_WRITE_REG: begin
            writenum = rd;
            write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
